// File: rtl/softmax_argmax_stream.sv
// softmax_argmax_stream
// Streaming argmax stage that sits after the softmax network. It takes one
// signed Q(WIDTH-FRAC).FRAC element per cycle and emits the winning class
// index and value once per OUT_SIZE-element vector. It also counts results
// per BATCH vectors.
//
// Optional feature: define ARGMAX_LOW_CONF_EN to build the low-confidence
// flag (m_max < CONF_THRESH). If it is not defined, m_low_conf is tied to 0.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   clear           synchronous clear of the partial vector, counters and outputs
//   s_valid/s_ready input element handshake (s_ready is combinational)
//   s_data          signed element; element k of a vector is class k
//   m_valid/m_ready result handshake
//   m_index, m_max  argmax class index and its value
//   vec_count       results loaded in the current batch, modulo BATCH
//   batch_done      one-cycle pulse alongside the BATCH-th result
//   m_low_conf      result value below CONF_THRESH (feature builds only)
module softmax_argmax_stream #(
  parameter int WIDTH       = 16,
  parameter int FRAC        = 8,
  parameter int OUT_SIZE    = 3,
  parameter int BATCH       = 300,
  parameter int CONF_THRESH = 128,
  localparam int IDX_W = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1,
  localparam int CNT_W = (BATCH > 1) ? $clog2(BATCH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [WIDTH-1:0] s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [IDX_W-1:0]        m_index,
  output logic signed [WIDTH-1:0] m_max,
  output logic [CNT_W-1:0]        vec_count,
  output logic                    batch_done,
  output logic                    m_low_conf
);

  typedef enum logic {FIRST, ACC} state_t;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        elem_cnt;
  logic signed [WIDTH-1:0] run_max;
  logic [IDX_W-1:0]        run_idx;

  logic                    accept;
  logic                    last;
  logic                    load;
  logic signed [WIDTH-1:0] cand_max;
  logic [IDX_W-1:0]        cand_idx;

  // FRAC only documents the number format. It is read here so that it does
  // not show up as an unused parameter.
  logic unused_cfg;
  assign unused_cfg = (FRAC < 0) ^ (CONF_THRESH < 0);

  // The input stalls whenever a result is waiting and is not being taken this
  // cycle. It also stalls during clear, so nothing slips in while clearing.
  assign s_ready = !clear && (!m_valid || m_ready);
  assign accept  = s_valid && s_ready;

  // This compare already includes the element being accepted. The last
  // element of a vector can therefore load the result directly, without an
  // extra cycle. The strict greater-than keeps the lowest index on a tie.
  always_comb begin
    cand_max = run_max;
    cand_idx = run_idx;
    last     = 1'b0;
    if (state == FIRST) begin
      cand_max = s_data;
      cand_idx = '0;
      last     = (OUT_SIZE == 1);
    end else begin
      if (s_data > run_max) begin
        cand_max = s_data;
        cand_idx = elem_cnt;
      end
      last = (elem_cnt == IDX_W'(OUT_SIZE - 1));
    end
  end

  assign load = accept && last;

  // Next-state logic. A completed vector always returns to FIRST. With
  // OUT_SIZE=1, every element is a last element, so the FSM never leaves FIRST.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = FIRST;
    end else if (accept) begin
      state_nxt = last ? FIRST : ACC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FIRST;
    end else begin
      state <= state_nxt;
    end
  end

  // Running max and element counter, plus the output register. When a new
  // result loads, it takes priority over the drop of m_valid. A result taken
  // in the same cycle is simply replaced, and m_valid stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_cnt   <= '0;
      run_max    <= '0;
      run_idx    <= '0;
      m_valid    <= 1'b0;
      m_index    <= '0;
      m_max      <= '0;
      vec_count  <= '0;
      batch_done <= 1'b0;
    end else if (clear) begin
      elem_cnt   <= '0;
      run_max    <= '0;
      run_idx    <= '0;
      m_valid    <= 1'b0;
      m_index    <= '0;
      m_max      <= '0;
      vec_count  <= '0;
      batch_done <= 1'b0;
    end else begin
      batch_done <= 1'b0;
      if (accept) begin
        run_max  <= cand_max;
        run_idx  <= cand_idx;
        elem_cnt <= last ? '0 : elem_cnt + 1'b1;
      end
      if (load) begin
        m_valid <= 1'b1;
        m_index <= cand_idx;
        m_max   <= cand_max;
        if (vec_count == CNT_W'(BATCH - 1)) begin
          vec_count  <= '0;
          batch_done <= 1'b1;
        end else begin
          vec_count <= vec_count + 1'b1;
        end
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

`ifdef ARGMAX_LOW_CONF_EN
  localparam logic signed [WIDTH-1:0] THRESH = WIDTH'(CONF_THRESH);

  // The flag is registered alongside m_max. It therefore holds exactly as
  // long as the result it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_low_conf <= 1'b0;
    end else if (clear) begin
      m_low_conf <= 1'b0;
    end else if (load) begin
      m_low_conf <= (cand_max < THRESH);
    end
  end
`else
  assign m_low_conf = 1'b0;
`endif

endmodule

// File: tb/tb_softmax_argmax_stream.sv
module tb_softmax_argmax_stream;

  localparam int WIDTH    = 16;
  localparam int OUT_SIZE = 3;
  localparam int BATCH    = 300;
  localparam int IDX_W    = 2;
  localparam int CNT_W    = 9;
`ifdef ARGMAX_LOW_CONF_EN
  localparam bit LC_EN = 1'b1;
`else
  localparam bit LC_EN = 1'b0;
`endif

  logic                    clk;
  logic                    rst_n;
  logic                    clear;
  logic                    s_valid;
  logic                    s_ready;
  logic signed [WIDTH-1:0] s_data;
  logic                    m_valid;
  logic                    m_ready;
  logic [IDX_W-1:0]        m_index;
  logic signed [WIDTH-1:0] m_max;
  logic [CNT_W-1:0]        vec_count;
  logic                    batch_done;
  logic                    m_low_conf;

  int total = 0;
  int bad   = 0;

  // Scoreboard for the stream test.
  bit mon_en      = 1'b0;
  bit stream_done = 1'b0;
  int got_idx[$];
  int got_max[$];
  int exp_idx[$];
  int exp_max[$];
  int bd_pulses   = 0;
  int bd_at       = -1;
  int bd_vcount   = -1;

  softmax_argmax_stream #(
    .WIDTH(WIDTH), .FRAC(8), .OUT_SIZE(OUT_SIZE), .BATCH(BATCH), .CONF_THRESH(128)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_index(m_index), .m_max(m_max),
    .vec_count(vec_count), .batch_done(batch_done), .m_low_conf(m_low_conf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Results are recorded at the falling edge. If m_valid && m_ready is true
  // there, the result is taken at the next rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (batch_done) begin
        bd_pulses = bd_pulses + 1;
        bd_at     = got_idx.size();
        bd_vcount = int'(vec_count);
      end
      if (m_valid && m_ready) begin
        got_idx.push_back(int'(m_index));
        got_max.push_back(int'(m_max));
      end
    end
  end

  task automatic applyStimulus(input int v);
    int waited;
    bit acc;
    s_valid = 1'b1;
    s_data  = WIDTH'(v);
    waited  = 0;
    acc     = 1'b0;
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    s_valid = 1'b0;
    if (!acc) begin
      total++; bad++;
      $display("[TB] FAIL send_timeout: element %0d not accepted within %0d cycles", v, waited);
    end
  endtask

  task automatic send_vec(input int a, input int b, input int c);
    applyStimulus(a);
    applyStimulus(b);
    applyStimulus(c);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_m_valid got=%0b want=0", m_valid); end
    total++; if (m_index !== '0) begin bad++; $display("[TB] FAIL reset_m_index got=%0d want=0", m_index); end
    total++; if (m_max !== '0) begin bad++; $display("[TB] FAIL reset_m_max got=%0d want=0", m_max); end
    total++; if (vec_count !== '0) begin bad++; $display("[TB] FAIL reset_vec_count got=%0d want=0", vec_count); end
    total++; if (batch_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_batch_done got=%0b want=0", batch_done); end
    total++; if (m_low_conf !== 1'b0) begin bad++; $display("[TB] FAIL reset_low_conf got=%0b want=0", m_low_conf); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_s_ready got=%0b want=1", s_ready); end
  endtask

  task automatic test_basic();
    @(posedge clk); #1;
    m_ready = 1'b1;
    applyStimulus(51);
    applyStimulus(179);
    total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_early_valid got=%0b want=0", m_valid); end
    applyStimulus(26);
    total++; if (m_valid !== 1'b1) begin bad++; $display("[TB] FAIL basic_latency got=%0b want=1", m_valid); end
    total++; if (m_index !== 2'd1) begin bad++; $display("[TB] FAIL basic_index got=%0d want=1", m_index); end
    total++; if (m_max !== 16'sd179) begin bad++; $display("[TB] FAIL basic_max got=%0d want=179", m_max); end
    total++; if (vec_count !== 9'd1) begin bad++; $display("[TB] FAIL basic_vec_count got=%0d want=1", vec_count); end
    @(posedge clk); #1;
    total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_consumed got=%0b want=0", m_valid); end
  endtask

  task automatic test_tie_negative();
    send_vec(128, 128, 0);
    total++; if (m_index !== 2'd0) begin bad++; $display("[TB] FAIL tie_index got=%0d want=0", m_index); end
    total++; if (m_max !== 16'sd128) begin bad++; $display("[TB] FAIL tie_max got=%0d want=128", m_max); end
    total++; if (m_low_conf !== 1'b0) begin bad++; $display("[TB] FAIL tie_low_conf got=%0b want=0", m_low_conf); end
    send_vec(-10, -5, -20);
    total++; if (m_index !== 2'd1) begin bad++; $display("[TB] FAIL neg_index got=%0d want=1", m_index); end
    total++; if (m_max !== -16'sd5) begin bad++; $display("[TB] FAIL neg_max got=%0d want=-5", m_max); end
    total++; if (m_low_conf !== LC_EN) begin bad++; $display("[TB] FAIL neg_low_conf got=%0b want=%0b", m_low_conf, LC_EN); end
    total++; if (vec_count !== 9'd3) begin bad++; $display("[TB] FAIL neg_vec_count got=%0d want=3", vec_count); end
  endtask

  task automatic test_low_conf();
    send_vec(100, 90, 66);
    total++; if (m_index !== 2'd0) begin bad++; $display("[TB] FAIL lc1_index got=%0d want=0", m_index); end
    total++; if (m_low_conf !== LC_EN) begin bad++; $display("[TB] FAIL lc1_flag got=%0b want=%0b", m_low_conf, LC_EN); end
    send_vec(10, 230, 16);
    total++; if (m_max !== 16'sd230) begin bad++; $display("[TB] FAIL lc2_max got=%0d want=230", m_max); end
    total++; if (m_low_conf !== 1'b0) begin bad++; $display("[TB] FAIL lc2_flag got=%0b want=0", m_low_conf); end
  endtask

  task automatic test_backpressure();
    repeat (2) @(posedge clk);
    #1;
    m_ready = 1'b0;
    send_vec(200, 10, 40);
    s_valid = 1'b1;
    s_data  = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++; if (s_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_s_ready cyc=%0d got=%0b want=0", i, s_ready); end
      total++; if (m_valid !== 1'b1 || m_index !== 2'd0 || m_max !== 16'sd200) begin
        bad++; $display("[TB] FAIL bp_hold cyc=%0d got v=%0b i=%0d m=%0d want v=1 i=0 m=200", i, m_valid, m_index, m_max);
      end
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    send_vec(0, 0, 90);
    total++; if (m_index !== 2'd2) begin bad++; $display("[TB] FAIL bp_next_index got=%0d want=2", m_index); end
    total++; if (m_max !== 16'sd90) begin bad++; $display("[TB] FAIL bp_next_max got=%0d want=90", m_max); end
  endtask

  task automatic test_reset_mid();
    applyStimulus(70);
    applyStimulus(80);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    total++; if (m_valid !== 1'b0 || vec_count !== '0) begin
      bad++; $display("[TB] FAIL rstmid_state got v=%0b cnt=%0d want v=0 cnt=0", m_valid, vec_count);
    end
    @(posedge clk); #1;
    send_vec(5, 9, 1);
    total++; if (m_index !== 2'd1 || m_max !== 16'sd9) begin
      bad++; $display("[TB] FAIL rstmid_result got i=%0d m=%0d want i=1 m=9", m_index, m_max);
    end
    // Clear in the middle of a vector, with an element presented that must not be taken.
    applyStimulus(70);
    applyStimulus(80);
    clear   = 1'b1;
    s_valid = 1'b1;
    s_data  = 16'sd99;
    @(negedge clk);
    total++; if (s_ready !== 1'b0) begin bad++; $display("[TB] FAIL clear_s_ready got=%0b want=0", s_ready); end
    @(posedge clk); #1;
    clear   = 1'b0;
    s_valid = 1'b0;
    total++; if (m_valid !== 1'b0 || vec_count !== '0) begin
      bad++; $display("[TB] FAIL clear_state got v=%0b cnt=%0d want v=0 cnt=0", m_valid, vec_count);
    end
    send_vec(5, 9, 1);
    total++; if (m_index !== 2'd1 || m_max !== 16'sd9) begin
      bad++; $display("[TB] FAIL clear_result got i=%0d m=%0d want i=1 m=9", m_index, m_max);
    end
    total++; if (vec_count !== 9'd1) begin bad++; $display("[TB] FAIL clear_vec_count got=%0d want=1", vec_count); end
  endtask

  task automatic test_stream();
    int errs;
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    mon_en = 1'b1;
    fork
      begin
        for (int v = 0; v < BATCH; v++) begin
          int a, b, c, mi, mx;
          a = int'($urandom_range(0, 7)) * 32 - 64;
          b = int'($urandom_range(0, 7)) * 32 - 64;
          c = int'($urandom_range(0, 7)) * 32 - 64;
          mi = 0; mx = a;
          if (b > mx) begin mi = 1; mx = b; end
          if (c > mx) begin mi = 2; mx = c; end
          exp_idx.push_back(mi);
          exp_max.push_back(mx);
          send_vec(a, b, c);
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk); #1;
          m_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    mon_en = 1'b0;
    total++; if (got_idx.size() != BATCH) begin bad++; $display("[TB] FAIL stream_count got=%0d want=%0d", got_idx.size(), BATCH); end
    errs = 0;
    for (int i = 0; i < BATCH && i < got_idx.size(); i++) begin
      if (got_idx[i] != exp_idx[i] || got_max[i] != exp_max[i]) begin
        errs++;
        if (errs <= 5) $display("[TB] FAIL stream_result n=%0d got i=%0d m=%0d want i=%0d m=%0d", i, got_idx[i], got_max[i], exp_idx[i], exp_max[i]);
      end
    end
    total++; if (errs != 0) bad++;
    total++; if (bd_pulses != 1) begin bad++; $display("[TB] FAIL stream_bd_pulses got=%0d want=1", bd_pulses); end
    total++; if (bd_at != BATCH - 1) begin bad++; $display("[TB] FAIL stream_bd_position got=%0d want=%0d", bd_at, BATCH - 1); end
    total++; if (bd_vcount != 0) begin bad++; $display("[TB] FAIL stream_bd_vec_count got=%0d want=0", bd_vcount); end
    total++; if (vec_count !== '0) begin bad++; $display("[TB] FAIL stream_wrap got=%0d want=0", vec_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie_negative();
    test_low_conf();
    test_backpressure();
    test_reset_mid();
    test_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
